// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - instruction fetch control FSM with pause/continue stepping
module fetch_sequencer #(
  parameter int unsigned MEM_WAIT = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run_i,
  input  logic        continue_i,
  output logic        ld_mar,
  output logic        ld_mdr,
  output logic        ld_ir,
  output logic        ld_pc,
  output logic        gate_pc,
  output logic        gate_mdr,
  output logic [1:0]  pcmux,
  output logic        mem_mem_ena,
  output logic        mem_wr_ena,
  output logic [2:0]  state_o,
  output logic [15:0] fetch_count
);

  typedef enum logic [2:0] {
    HALTED     = 3'd0,
    FETCH_ADDR = 3'd1,
    MEM_READ   = 3'd2,
    LOAD_IR    = 3'd3,
    PAUSE_WAIT = 3'd4,
    PAUSE_REL  = 3'd5
  } state_t;

  localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT - 1);

  state_t     state;
  state_t     state_nxt;
  logic [3:0] wait_cnt;
  logic [3:0] wait_nxt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= HALTED;
      wait_cnt    <= 4'd0;
      fetch_count <= 16'h0000;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      // Every LOAD_IR cycle is followed by PAUSE_WAIT, so this counts completed fetches.
      if (state == LOAD_IR) begin
        fetch_count <= fetch_count + 16'd1;
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    wait_nxt    = wait_cnt;
    ld_mar      = 1'b0;
    ld_mdr      = 1'b0;
    ld_ir       = 1'b0;
    ld_pc       = 1'b0;
    gate_pc     = 1'b0;
    gate_mdr    = 1'b0;
    mem_mem_ena = 1'b0;
    case (state)
      HALTED: begin
        if (run_i) state_nxt = FETCH_ADDR;
      end
      FETCH_ADDR: begin
        gate_pc   = 1'b1;
        ld_mar    = 1'b1;
        ld_pc     = 1'b1;
        wait_nxt  = 4'd0;
        state_nxt = MEM_READ;
      end
      MEM_READ: begin
        mem_mem_ena = 1'b1;
        ld_mdr      = 1'b1;
        wait_nxt    = wait_cnt + 4'd1;
        if (wait_cnt == WAIT_LAST) state_nxt = LOAD_IR;
      end
      LOAD_IR: begin
        gate_mdr  = 1'b1;
        ld_ir     = 1'b1;
        state_nxt = PAUSE_WAIT;
      end
      PAUSE_WAIT: begin
        if (continue_i) state_nxt = PAUSE_REL;
      end
      PAUSE_REL: begin
        // Wait for release so a held continue produces a single fetch.
        if (!continue_i) state_nxt = FETCH_ADDR;
      end
      default: state_nxt = HALTED;
    endcase
  end

  assign pcmux      = 2'b00;
  assign mem_wr_ena = 1'b0;
  assign state_o    = state;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - directed self-checking bench for fetch_sequencer
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        run_i;
  logic        continue_i;
  logic        ld_mar, ld_mdr, ld_ir, ld_pc, gate_pc, gate_mdr;
  logic [1:0]  pcmux;
  logic        mem_mem_ena, mem_wr_ena;
  logic [2:0]  state_o;
  logic [15:0] fetch_count;
  logic [6:0]  ctrl;

  int compared   = 0;
  int mismatched = 0;
  bit done       = 1'b0;

  fetch_sequencer #(.MEM_WAIT(3)) dut (
    .clk(clk), .reset(reset), .run_i(run_i), .continue_i(continue_i),
    .ld_mar(ld_mar), .ld_mdr(ld_mdr), .ld_ir(ld_ir), .ld_pc(ld_pc),
    .gate_pc(gate_pc), .gate_mdr(gate_mdr), .pcmux(pcmux),
    .mem_mem_ena(mem_mem_ena), .mem_wr_ena(mem_wr_ena),
    .state_o(state_o), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  assign ctrl = {ld_mar, ld_mdr, ld_ir, ld_pc, gate_pc, gate_mdr, mem_mem_ena};

  // Expected {ld_mar,ld_mdr,ld_ir,ld_pc,gate_pc,gate_mdr,mem_mem_ena} per state
  function automatic logic [6:0] ctrl_for(input logic [2:0] s);
    case (s)
      3'd1:    return 7'b1001100;
      3'd2:    return 7'b0100001;
      3'd3:    return 7'b0010010;
      default: return 7'b0000000;
    endcase
  endfunction

  always @(negedge clk) begin
    if (!done) begin
      compared++;
      if (mem_wr_ena !== 1'b0 || pcmux !== 2'b00 || (gate_pc === 1'b1 && gate_mdr === 1'b1)
          || state_o === 3'd6 || state_o === 3'd7 || $isunknown(state_o)) begin
        mismatched++;
        $display("FAIL invariant t=%0t: wr=%b pcmux=%b gate_pc=%b gate_mdr=%b state=%0d, required wr=0 pcmux=00 no dual gate state<6",
                 $time, mem_wr_ena, pcmux, gate_pc, gate_mdr, state_o);
      end
    end
  end

  task automatic test_reset();
    run_i = 1'b0; continue_i = 1'b0; reset = 1'b1;
    #1 reset = 1'b0;
    repeat (2) @(negedge clk);
    compared++;
    if (state_o !== 3'd0 || fetch_count !== 16'h0000 || ctrl !== 7'b0) begin
      mismatched++;
      $display("FAIL reset_state: state=%0d count=%h ctrl=%b, required 0 0000 0000000", state_o, fetch_count, ctrl);
    end
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      compared++;
      if (state_o !== 3'd0) begin
        mismatched++;
        $display("FAIL reset_idle step %0d: state=%0d, required 0", i, state_o);
      end
    end
  endtask

  task automatic test_single_fetch();
    logic [2:0] seq [6];
    int ir_pulses;
    seq = '{3'd1, 3'd2, 3'd2, 3'd2, 3'd3, 3'd4};
    ir_pulses = 0;
    run_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 0) run_i = 1'b0;
      if (ld_ir === 1'b1) ir_pulses++;
      compared++;
      if (state_o !== seq[i] || ctrl !== ctrl_for(seq[i])) begin
        mismatched++;
        $display("FAIL single_fetch step %0d: state=%0d ctrl=%b, required state=%0d ctrl=%b",
                 i, state_o, ctrl, seq[i], ctrl_for(seq[i]));
      end
    end
    compared++;
    if (ir_pulses != 1 || fetch_count !== 16'd1) begin
      mismatched++;
      $display("FAIL single_fetch_count: ld_ir pulses=%0d count=%0d, required 1 1", ir_pulses, fetch_count);
    end
  endtask

  task automatic test_continue();
    logic [2:0] seq [6];
    seq = '{3'd1, 3'd2, 3'd2, 3'd2, 3'd3, 3'd4};
    continue_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      compared++;
      if (state_o !== 3'd5 || fetch_count !== 16'd1) begin
        mismatched++;
        $display("FAIL continue_hold step %0d: state=%0d count=%0d, required 5 1", i, state_o, fetch_count);
      end
    end
    continue_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      compared++;
      if (state_o !== seq[i] || ctrl !== ctrl_for(seq[i])) begin
        mismatched++;
        $display("FAIL continue_fetch step %0d: state=%0d ctrl=%b, required state=%0d ctrl=%b",
                 i, state_o, ctrl, seq[i], ctrl_for(seq[i]));
      end
    end
    compared++;
    if (fetch_count !== 16'd2) begin
      mismatched++;
      $display("FAIL continue_count: count=%0d, required 2", fetch_count);
    end
  endtask

  task automatic test_ignore_run();
    run_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      compared++;
      if (state_o !== 3'd4) begin
        mismatched++;
        $display("FAIL ignore_run step %0d: state=%0d, required 4", i, state_o);
      end
    end
    run_i = 1'b0;
  endtask

  task automatic test_reset_mid();
    continue_i = 1'b1;
    @(negedge clk);
    continue_i = 1'b0;
    repeat (3) @(negedge clk);
    compared++;
    if (state_o !== 3'd2) begin
      mismatched++;
      $display("FAIL reset_mid_setup: state=%0d, required 2", state_o);
    end
    #2 reset = 1'b0;
    #1;
    compared++;
    if (state_o !== 3'd0 || ctrl !== 7'b0 || fetch_count !== 16'h0000) begin
      mismatched++;
      $display("FAIL reset_async: state=%0d ctrl=%b count=%h, required 0 0000000 0000", state_o, ctrl, fetch_count);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      compared++;
      if (ld_ir !== 1'b0 || state_o !== 3'd0) begin
        mismatched++;
        $display("FAIL reset_hold step %0d: ld_ir=%b state=%0d, required 0 0", i, ld_ir, state_o);
      end
    end
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      compared++;
      if (state_o !== 3'd0 || fetch_count !== 16'h0000) begin
        mismatched++;
        $display("FAIL reset_release step %0d: state=%0d count=%h, required 0 0000", i, state_o, fetch_count);
      end
    end
  endtask

  task automatic test_run_and_continue();
    logic [2:0] seq1 [9];
    logic [2:0] seq2 [6];
    seq1 = '{3'd1, 3'd2, 3'd2, 3'd2, 3'd3, 3'd4, 3'd5, 3'd5, 3'd5};
    seq2 = '{3'd1, 3'd2, 3'd2, 3'd2, 3'd3, 3'd4};
    run_i = 1'b1;
    continue_i = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (i == 0) run_i = 1'b0;
      compared++;
      if (state_o !== seq1[i]) begin
        mismatched++;
        $display("FAIL run_cont step %0d: state=%0d, required %0d", i, state_o, seq1[i]);
      end
    end
    compared++;
    if (fetch_count !== 16'd1) begin
      mismatched++;
      $display("FAIL run_cont_count1: count=%0d, required 1", fetch_count);
    end
    continue_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      compared++;
      if (state_o !== seq2[i]) begin
        mismatched++;
        $display("FAIL run_cont_release step %0d: state=%0d, required %0d", i, state_o, seq2[i]);
      end
    end
    compared++;
    if (fetch_count !== 16'd2) begin
      mismatched++;
      $display("FAIL run_cont_count2: count=%0d, required 2", fetch_count);
    end
  endtask

  task automatic test_wrap();
    force dut.fetch_count = 16'hFFFF;
    #1 release dut.fetch_count;
    #1;
    compared++;
    if (fetch_count !== 16'hFFFF) begin
      mismatched++;
      $display("FAIL wrap_preload: count=%h, required ffff", fetch_count);
    end
    @(negedge clk);
    continue_i = 1'b1;
    @(negedge clk);
    continue_i = 1'b0;
    repeat (6) @(negedge clk);
    compared++;
    if (fetch_count !== 16'h0000 || state_o !== 3'd4) begin
      mismatched++;
      $display("FAIL wrap: count=%h state=%0d, required 0000 4", fetch_count, state_o);
    end
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_continue();
    test_ignore_run();
    test_reset_mid();
    test_run_and_continue();
    test_wrap();
    done = 1'b1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
